// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Lets two requesters share one single-ported data memory: r0 is the core
//   load/store unit and r1 is the debug/DMA port. At most one access is granted
//   per cycle. Grants alternate round-robin. A requester can lock the bus so that
//   it keeps exclusive ownership across a read-modify-write sequence. Accesses
//   that are out of range or misaligned, and accesses that use an illegal size
//   code, are answered with an error and never reach the memory.
//
// Ports
//   i_clk, i_reset        clock and asynchronous active-high reset
//   i_rN_valid/o_rN_ready request handshake (N = 0,1); ready is combinational
//   i_rN_addr/wdata       byte address and store data
//   i_rN_funct3/we        RISC-V load/store size code and the store flag
//   i_rN_lock             keep ownership of the bus after this transfer
//   o_rN_rsp_valid/rdata/err
//                         one-cycle response on the edge after acceptance
//   o_mem_*               request to the memory; all zero when nothing is granted
//   i_mem_read_data       combinational read data from the memory
module dmem_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int LOCK_MAX  = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_r0_valid,
    output logic        o_r0_ready,
    input  logic [31:0] i_r0_addr,
    input  logic [31:0] i_r0_wdata,
    input  logic [2:0]  i_r0_funct3,
    input  logic        i_r0_we,
    input  logic        i_r0_lock,
    output logic        o_r0_rsp_valid,
    output logic [31:0] o_r0_rsp_rdata,
    output logic        o_r0_rsp_err,
    input  logic        i_r1_valid,
    output logic        o_r1_ready,
    input  logic [31:0] i_r1_addr,
    input  logic [31:0] i_r1_wdata,
    input  logic [2:0]  i_r1_funct3,
    input  logic        i_r1_we,
    input  logic        i_r1_lock,
    output logic        o_r1_rsp_valid,
    output logic [31:0] o_r1_rsp_rdata,
    output logic        o_r1_rsp_err,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    output logic [2:0]  o_mem_funct3,
    output logic        o_mem_read_enable,
    output logic        o_mem_write_enable,
    input  logic [31:0] i_mem_read_data
);

    localparam int LC_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last_grant;
    logic [LC_W-1:0] r_lock_cnt;

    logic [1:0]  w_valid;
    logic [1:0]  w_grant;
    logic        w_sel;
    logic        w_any;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_funct3;
    logic        w_we;
    logic        w_lock;
    logic        w_range_err;
    logic        w_misalign;
    logic        w_bad_code;
    logic        w_fault;
    logic        w_legal;
    logic        w_lock_expire;

    assign w_valid = {i_r1_valid, i_r0_valid};

    // Grant selection. Nothing is granted while reset is held, so a request
    // presented during reset is never accepted.
    always_comb begin
        w_grant = 2'b00;
        if (!i_reset) begin
            case (r_state)
                ST_OWN0: w_grant[0] = w_valid[0];
                ST_OWN1: w_grant[1] = w_valid[1];
                default: begin
                    if (&w_valid) begin
                        // Contention: the requester that did not win last time goes.
                        w_grant[0] = r_last_grant;
                        w_grant[1] = ~r_last_grant;
                    end else begin
                        w_grant = w_valid;
                    end
                end
            endcase
        end
    end

    assign w_sel    = w_grant[1];
    assign w_any    = |w_grant;
    assign w_addr   = w_sel ? i_r1_addr   : i_r0_addr;
    assign w_wdata  = w_sel ? i_r1_wdata  : i_r0_wdata;
    assign w_funct3 = w_sel ? i_r1_funct3 : i_r0_funct3;
    assign w_we     = w_sel ? i_r1_we     : i_r0_we;
    assign w_lock   = w_sel ? i_r1_lock   : i_r0_lock;

    // funct3[1:0] encodes the access size: 00 byte, 01 halfword, 10 word.
    assign w_range_err = |w_addr[31:ADDR_BITS];
    assign w_misalign  = ((w_funct3[1:0] == 2'b01) && w_addr[0])
                       || ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    assign w_bad_code  = w_we ? (w_funct3 > 3'd2)
                              : ((w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7));
    assign w_fault     = w_range_err | w_misalign | w_bad_code;
    assign w_legal     = w_any & ~w_fault;

    assign w_lock_expire = (r_lock_cnt == LC_W'(LOCK_MAX - 1));

    assign o_r0_ready         = w_grant[0];
    assign o_r1_ready         = w_grant[1];
    assign o_mem_address      = w_any ? w_addr   : 32'd0;
    assign o_mem_write_data   = w_any ? w_wdata  : 32'd0;
    assign o_mem_funct3       = w_any ? w_funct3 : 3'd0;
    assign o_mem_read_enable  = w_legal & ~w_we;
    assign o_mem_write_enable = w_legal & w_we;

    // Ownership and round-robin state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_lock_cnt   <= '0;
        end else begin
            if (w_any) begin
                r_last_grant <= w_sel;
            end
            case (r_state)
                ST_IDLE: begin
                    // A faulted transfer never takes the lock.
                    if (w_any && w_lock && !w_fault) begin
                        r_state    <= w_sel ? ST_OWN1 : ST_OWN0;
                        r_lock_cnt <= '0;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                    if (w_lock_expire) begin
                        // Forced release: mark the owner as last winner so the
                        // other requester gets the next contended grant.
                        r_state      <= ST_IDLE;
                        r_last_grant <= (r_state == ST_OWN1);
                    end else if (w_any && !w_lock) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Per-requester response registers.
    logic [1:0]  w_rsp_valid;
    logic [1:0]  w_rsp_err;
    logic [31:0] w_rsp_rdata [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic        r_valid;
        logic        r_err;
        logic [31:0] r_rdata;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_rdata <= 32'd0;
            end else begin
                r_valid <= w_grant[gi];
                r_err   <= w_grant[gi] & w_fault;
                r_rdata <= (w_grant[gi] && w_legal && !w_we) ? i_mem_read_data : 32'd0;
            end
        end

        assign w_rsp_valid[gi] = r_valid;
        assign w_rsp_err[gi]   = r_err;
        assign w_rsp_rdata[gi] = r_rdata;
    end

    assign o_r0_rsp_valid = w_rsp_valid[0];
    assign o_r0_rsp_err   = w_rsp_err[0];
    assign o_r0_rsp_rdata = w_rsp_rdata[0];
    assign o_r1_rsp_valid = w_rsp_valid[1];
    assign o_r1_rsp_err   = w_rsp_err[1];
    assign o_r1_rsp_rdata = w_rsp_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. A byte-array memory sits on the mem_* port.
//   A separate reference model uses its own golden memory and predicts the
//   grants, mem_* outputs and responses on every cycle. Literal checks in the
//   stimulus pin the headline scenarios.
module tb_dmem_arbiter;

    localparam int ADDR_BITS = 12;
    localparam int LOCK_MAX  = 16;
    localparam int MEM_BYTES = 1 << ADDR_BITS;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        lock;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam req_t NOP = '0;

    logic clk = 1'b0;
    logic reset;
    req_t q0, q1;

    logic        r0_ready, r1_ready;
    logic        r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
    logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_rd;
    logic [2:0]  mem_funct3;
    logic        mem_read_enable, mem_write_enable;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_BITS(ADDR_BITS), .LOCK_MAX(LOCK_MAX)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_r0_valid(q0.valid), .o_r0_ready(r0_ready), .i_r0_addr(q0.addr),
        .i_r0_wdata(q0.wdata), .i_r0_funct3(q0.f3), .i_r0_we(q0.we), .i_r0_lock(q0.lock),
        .o_r0_rsp_valid(r0_rsp_valid), .o_r0_rsp_rdata(r0_rsp_rdata), .o_r0_rsp_err(r0_rsp_err),
        .i_r1_valid(q1.valid), .o_r1_ready(r1_ready), .i_r1_addr(q1.addr),
        .i_r1_wdata(q1.wdata), .i_r1_funct3(q1.f3), .i_r1_we(q1.we), .i_r1_lock(q1.lock),
        .o_r1_rsp_valid(r1_rsp_valid), .o_r1_rsp_rdata(r1_rsp_rdata), .o_r1_rsp_err(r1_rsp_err),
        .o_mem_address(mem_address), .o_mem_write_data(mem_write_data),
        .o_mem_funct3(mem_funct3), .o_mem_read_enable(mem_read_enable),
        .o_mem_write_enable(mem_write_enable), .i_mem_read_data(mem_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory helpers ----------------
    logic [7:0] phys_mem [0:MEM_BYTES-1];
    logic [7:0] gold_mem [0:MEM_BYTES-1];

    function automatic int acc_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // Little-endian word starting at the access address, sized/extended by funct3.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd2:    return w;
            3'd4:    return {24'd0, w[7:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    // Memory on the DUT port; a non-zero pattern stands in for the undriven bus.
    logic [ADDR_BITS-1:0] rd_idx;
    logic [31:0]          rd_word;
    always_comb begin
        mem_rd  = 32'hBAD0_BAD0;
        rd_idx  = mem_address[ADDR_BITS-1:0];
        rd_word = {phys_mem[rd_idx + ADDR_BITS'(3)], phys_mem[rd_idx + ADDR_BITS'(2)],
                   phys_mem[rd_idx + ADDR_BITS'(1)], phys_mem[rd_idx]};
        if (mem_read_enable) mem_rd = load_ext(rd_word, mem_funct3);
    end

    // Stores land mid-cycle; only one access happens per cycle, so a load in the
    // same cycle cannot observe them.
    initial forever begin
        @(negedge clk);
        if (!reset && mem_write_enable) begin
            for (int k = 0; k < acc_bytes(mem_funct3); k++)
                phys_mem[mem_address[ADDR_BITS-1:0] + ADDR_BITS'(k)] = mem_write_data[8*k +: 8];
        end
    end

    function automatic logic [31:0] gold_load(input logic [31:0] a, input logic [2:0] f3);
        logic [ADDR_BITS-1:0] i;
        i = a[ADDR_BITS-1:0];
        return load_ext({gold_mem[i + ADDR_BITS'(3)], gold_mem[i + ADDR_BITS'(2)],
                         gold_mem[i + ADDR_BITS'(1)], gold_mem[i]}, f3);
    endfunction

    function automatic bit is_fault(input req_t r);
        if (r.addr >= 32'(MEM_BYTES)) return 1'b1;
        if (r.we) begin
            if (r.f3 > 3'd2) return 1'b1;
        end else if (r.f3 == 3'd3 || r.f3 == 3'd6 || r.f3 == 3'd7) begin
            return 1'b1;
        end
        if ((r.addr % 32'(acc_bytes(r.f3))) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- reference model + compare ----------------
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_last  = 1;
    int          m_win;
    req_t        m_req;
    bit          m_flt;
    logic [1:0]  exp_rv  = 2'b00;
    logic [1:0]  exp_err = 2'b00;
    logic [31:0] exp_rd0 = 32'd0;
    logic [31:0] exp_rd1 = 32'd0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("rst_ctl", 32'({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid,
                                  r0_rsp_err, r1_rsp_err, mem_read_enable, mem_write_enable}), 32'd0);
            check("rst_data", r0_rsp_rdata | r1_rsp_rdata | mem_address | mem_write_data
                              | 32'(mem_funct3), 32'd0);
            m_owner = -1; m_age = 0; m_last = 1;
            exp_rv = 2'b00; exp_err = 2'b00; exp_rd0 = 32'd0; exp_rd1 = 32'd0;
        end else begin
            check("rsp_valid", 32'({r1_rsp_valid, r0_rsp_valid}), 32'(exp_rv));
            check("rsp_err",   32'({r1_rsp_err, r0_rsp_err}),     32'(exp_err));
            check("rsp0_rdata", r0_rsp_rdata, exp_rd0);
            check("rsp1_rdata", r1_rsp_rdata, exp_rd1);

            m_win = -1;
            if (m_owner == 0)      begin if (q0.valid) m_win = 0; end
            else if (m_owner == 1) begin if (q1.valid) m_win = 1; end
            else if (q0.valid && q1.valid) m_win = 1 - m_last;
            else if (q0.valid) m_win = 0;
            else if (q1.valid) m_win = 1;

            m_req = (m_win == 1) ? q1 : q0;
            m_flt = (m_win >= 0) && is_fault(m_req);

            check("ready", 32'({r1_ready, r0_ready}), 32'({m_win == 1, m_win == 0}));
            if (m_win < 0) begin
                check("mem_idle", mem_address | mem_write_data | 32'(mem_funct3)
                                  | 32'({mem_read_enable, mem_write_enable}), 32'd0);
            end else begin
                check("mem_addr",  mem_address, m_req.addr);
                check("mem_wdata", mem_write_data, m_req.wdata);
                check("mem_f3",    32'(mem_funct3), 32'(m_req.f3));
                check("mem_en",    32'({mem_read_enable, mem_write_enable}),
                                   32'({!m_flt && !m_req.we, !m_flt && m_req.we}));
            end

            exp_rv = 2'b00; exp_err = 2'b00; exp_rd0 = 32'd0; exp_rd1 = 32'd0;
            if (m_win >= 0) begin
                exp_rv[m_win]  = 1'b1;
                exp_err[m_win] = m_flt;
                if (!m_flt && !m_req.we) begin
                    if (m_win == 0) exp_rd0 = gold_load(m_req.addr, m_req.f3);
                    else            exp_rd1 = gold_load(m_req.addr, m_req.f3);
                end
                if (!m_flt && m_req.we)
                    for (int k = 0; k < acc_bytes(m_req.f3); k++)
                        gold_mem[m_req.addr[ADDR_BITS-1:0] + ADDR_BITS'(k)] = m_req.wdata[8*k +: 8];
                m_last = m_win;
            end

            if (m_owner < 0) begin
                if (m_win >= 0 && m_req.lock && !m_flt) begin
                    m_owner = m_win;
                    m_age   = 0;
                end
            end else if (m_age == LOCK_MAX - 1) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_win == m_owner && !m_req.lock) begin
                m_owner = -1;
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic req_t ld(input logic [31:0] a, input logic [2:0] f3 = 3'd2,
                                input logic lk = 1'b0);
        req_t r;
        r = '0; r.valid = 1'b1; r.addr = a; r.f3 = f3; r.lock = lk;
        return r;
    endfunction

    function automatic req_t st(input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f3 = 3'd2, input logic lk = 1'b0);
        req_t r;
        r = '0; r.valid = 1'b1; r.we = 1'b1; r.addr = a; r.wdata = d; r.f3 = f3; r.lock = lk;
        return r;
    endfunction

    logic s_rdy0, s_rdy1, s_re, s_we;

    // Drive one cycle; returns #1 after the edge, when that cycle's response is visible.
    task automatic step(input req_t a, input req_t b);
        q0 = a; q1 = b;
        @(negedge clk);
        s_rdy0 = r0_ready; s_rdy1 = r1_ready;
        s_re = mem_read_enable; s_we = mem_write_enable;
        @(posedge clk); #1;
        $display("[TB] step r0(v%0d we%0d a=%h) r1(v%0d we%0d a=%h) -> rdy=%0d%0d",
                 a.valid, a.we, a.addr, b.valid, b.we, b.addr, s_rdy1, s_rdy0);
    endtask

    task automatic do_reset();
        reset = 1'b1; q0 = NOP; q1 = NOP;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] g0, g1;
        bit         both, got;
        int         n;

        for (int i = 0; i < MEM_BYTES; i++) begin
            phys_mem[i] = 8'd0;
            gold_mem[i] = 8'd0;
        end
        reset = 1'b1; q0 = ld(32'h10); q1 = NOP;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_gated", 32'(r0_ready), 32'd0);
        reset = 1'b0; q0 = NOP;

        // 1: store then load on r0
        step(st(32'h10, 32'hDEADBEEF), NOP);
        check("t1_sw_ready", 32'(s_rdy0), 32'd1);
        check("t1_sw_rsp", 32'({r0_rsp_valid, r0_rsp_err}), 32'b10);
        step(ld(32'h10), NOP);
        check("t1_lw_rdata", r0_rsp_rdata, 32'hDEADBEEF);
        step(NOP, NOP);
        check("t1_rsp_pulse", 32'(r0_rsp_valid), 32'd0);

        // 2: contention straight after reset alternates r0,r1,r0,r1
        do_reset();
        g0 = '0; g1 = '0; both = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(ld(32'h10), ld(32'h20));
            g0[i] = s_rdy0; g1[i] = s_rdy1;
            both |= s_rdy0 & s_rdy1;
        end
        check("t2_r0_grants", 32'(g0), 32'h5);
        check("t2_r1_grants", 32'(g1), 32'hA);
        check("t2_never_both", 32'(both), 32'd0);

        // 3: sub-word loads on r1
        step(NOP, st(32'h10, 32'h80FF0000));
        step(NOP, ld(32'h13, 3'd0));
        check("t3_lb", r1_rsp_rdata, 32'hFFFFFF80);
        step(NOP, ld(32'h13, 3'd4));
        check("t3_lbu", r1_rsp_rdata, 32'h00000080);
        step(NOP, ld(32'h12, 3'd1));
        check("t3_lh", r1_rsp_rdata, 32'hFFFF80FF);
        step(NOP, ld(32'h12, 3'd5));
        check("t3_lhu", r1_rsp_rdata, 32'h000080FF);

        // 4: faults
        step(ld(32'h1000), NOP);
        check("t4_range_err", 32'({r0_rsp_err, s_re, s_we}), 32'b100);
        check("t4_range_rdata", r0_rsp_rdata, 32'd0);
        step(ld(32'h11, 3'd1), NOP);
        check("t4_lh_misalign", 32'({r0_rsp_err, s_re, s_we}), 32'b100);
        step(st(32'h10, 32'h12345678, 3'd3), NOP);
        check("t4_bad_store", 32'({r0_rsp_err, s_we}), 32'b10);
        step(ld(32'h10, 3'd6), NOP);
        step(ld(32'h12), NOP);
        check("t4_lw_misalign", 32'(r0_rsp_err), 32'd1);
        step(st(32'h0FFC, 32'hA5A5A5A5), NOP);
        step(ld(32'h0FFC), NOP);
        check("t4_top_word", r0_rsp_rdata, 32'hA5A5A5A5);
        step(ld(32'h10), NOP);
        check("t4_no_fault_write", r0_rsp_rdata, 32'h80FF0000);

        // 5: lock held by r0 until forced release
        step(ld(32'h10, 3'd2, 1'b1), NOP);
        n = 0; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step(NOP, ld(32'h20));
            n++;
            if (s_rdy1) got = 1'b1;
        end
        check("t5_granted", 32'(got), 32'd1);
        check("t5_grant_cycle", 32'(n), 32'd17);
        // release by an unlocked transfer from the owner
        step(ld(32'h14, 3'd2, 1'b1), NOP);
        step(ld(32'h14), ld(32'h20));
        check("t5_owner_only", 32'({s_rdy1, s_rdy0}), 32'b01);
        step(NOP, ld(32'h20));
        check("t5_after_unlock", 32'(s_rdy1), 32'd1);

        // 6: reset while r1 owns the bus
        step(NOP, ld(32'h20, 3'd2, 1'b1));
        step(ld(32'h10), ld(32'h20, 3'd2, 1'b1));
        check("t6_locked_out", 32'({s_rdy1, s_rdy0}), 32'b10);
        reset = 1'b1; q0 = ld(32'h10); q1 = NOP;
        @(negedge clk);
        check("t6_rst_no_rsp", 32'({r1_rsp_valid, r0_ready}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(ld(32'h10), ld(32'h20, 3'd2, 1'b1));
        check("t6_r0_first", 32'({s_rdy1, s_rdy0}), 32'b01);
        check("t6_rsp", 32'({r1_rsp_valid, r0_rsp_valid}), 32'b01);
        step(NOP, NOP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
